keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//   4x4 matrix keypad scanner: drives rows, samples columns, debounces and encodes one key press
//   into the 4-bit keypad code plus strobe/held flags consumed by the alarm siren controller.
//   Sits between the keypad connector pins and the siren's keypad input, on the board clock.
// PARAMETERS
//   DIV_PAR         2500000  scan tick period in clk cycles (tick counter runs 1..DIV_PAR, >=4, <2^25)
//   DEBOUNCE_TICKS  4        consecutive stable ticks required for press and for release (1..15)
//   REPEAT_TICKS    8        ticks between repeated strobes while held (only with KEYPAD_AUTOREPEAT_EN)
// PORTS
//   clk         in   1  board clock
//   reset_n     in   1  asynchronous active-low reset
//   cols_in     in   4  keypad columns, active-low (pulled up), asynchronous to clk
//   rows_out    out  4  row drive, one-cold (exactly one bit low at all times)
//   keypad      out  4  code of last accepted key = {row[1:0], col[1:0]}
//   key_strobe  out  1  one-clk pulse per accepted press (and per repeat, if enabled)
//   key_held    out  1  high from accepted press until accepted release
// BEHAVIOUR
//   - Reset (async, reset_n=0): rows_out=4'b1110, keypad=0, key_strobe=0, key_held=0, state SCAN,
//     tick counter=1, debounce/repeat counters=0, sync flops=4'b1111.
//   - cols_in passes a 2-FF synchronizer; all decisions use the synced value sampled on tick.
//   - tick: 25-bit counter; tick=1 when count==DIV_PAR, counter reloads to 1, else increments.
//   - All state changes below occur only on tick cycles, except key_strobe clearing next clk.
//   - SCAN: if synced cols has exactly one low bit -> latch row idx/col idx, deb_cnt=1, go DEBOUNCE,
//     rows_out holds. Zero or >=2 low bits -> rotate rows_out left (1110->1101->1011->0111->1110).
//   - DEBOUNCE: same single col low -> deb_cnt+1; when deb_cnt reaches DEBOUNCE_TICKS -> keypad=code,
//     key_strobe=1 for exactly one clk, key_held=1, go PRESSED. Any other pattern -> deb_cnt=0,
//     go SCAN, rotate rows. DEBOUNCE_TICKS=1: accept on the first SCAN tick that sees the key.
//   - PRESSED: rows_out holds; cols all high -> rel_cnt+1, else rel_cnt=0 (bounce restarts count).
//     rel_cnt reaching DEBOUNCE_TICKS -> key_held=0, rel_cnt=0, go SCAN, rotate rows.
//     Second key pressed while held: ignored; release requires all cols high.
//   - keypad retains last accepted code after release; only reset clears it.
//   - Latency: strobe asserted the clk after the tick on which the count reaches DEBOUNCE_TICKS.
//   - Simultaneous: strobe and key_held rise on the same clk; never strobe outside PRESSED entry/repeat.
//   - Row settling: each row is driven for >= DIV_PAR clks before sampling (covers sync latency).
// CONFIGURATION
//   KEYPAD_AUTOREPEAT_EN defined: in PRESSED, rep_cnt counts ticks with the key still low; every
//     REPEAT_TICKS ticks emit another one-clk key_strobe (keypad unchanged); rep_cnt clears on
//     entry to PRESSED and on any tick with cols not exactly the held column low.
//   Not defined: exactly one key_strobe per press; no repeat counter logic synthesized.
// TESTING  (bench uses DIV_PAR=4, DEBOUNCE_TICKS=3, REPEAT_TICKS=2)
//   1 Idle, cols=4'hF -> rows_out 1110,1101,1011,0111,1110 changing every 4 clks; no strobe.
//   2 Hold row2/col1 low (cols=4'b1101 when rows_out=1011) -> one strobe, keypad=4'h9, key_held=1;
//     release -> key_held=0 after 3 ticks, keypad stays 4'h9.
//   3 Bounce: col low 2 ticks then high -> no strobe, key_held=0, rows resume rotation.
//   4 Two cols low on same row (cols=4'b1100) -> no strobe, rotation continues.
//   5 reset_n=0 mid-DEBOUNCE -> same clk: rows_out=1110, keypad=0, strobe=0, held=0; restart clean.
//   6 Hold key 3+4 ticks: with KEYPAD_AUTOREPEAT_EN 3 strobes spaced 8 clks; without, 1 strobe.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-cold row drive, debounces a single column hit and
// emits the {row,col} code with a strobe/held flag. Optional auto-repeat: KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int DIV_PAR        = 2500000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] cols_in,
  output logic [3:0] rows_out,
  output logic [3:0] keypad,
  output logic       key_strobe,
  output logic       key_held
);

  localparam logic [24:0] DIV_VAL = DIV_PAR[24:0];
  localparam logic [3:0]  DEB_VAL = DEBOUNCE_TICKS[3:0];

  if (DIV_PAR < 4 || DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 15 || REPEAT_TICKS < 1)
    begin : g_bad_params
      $error("keypad_scanner: parameter out of range");
    end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t      state_reg;
  logic [3:0]  sync1_reg;
  logic [3:0]  sync2_reg;
  logic [24:0] tick_cnt_reg;
  logic        tick;
  logic [1:0]  row_idx_reg;
  logic [1:0]  col_idx_reg;
  logic [3:0]  deb_cnt_reg;
  logic [3:0]  rel_cnt_reg;
  logic [3:0]  col_hit;
  logic        one_low;
  logic        same_col;
  logic        all_high;
  logic [1:0]  low_idx;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [15:0] REP_VAL = REPEAT_TICKS[15:0];
  logic [15:0] rep_cnt_reg;
`endif

  // col_hit[gi] is set only when column gi is the single low column
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col_hit
      assign col_hit[gi] = (sync2_reg == ~(4'b0001 << gi));
    end
  endgenerate

  assign one_low  = |col_hit;
  assign same_col = col_hit[col_idx_reg];
  assign all_high = (sync2_reg == 4'hF);
  assign tick     = (tick_cnt_reg == DIV_VAL);

  always_comb begin
    low_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (col_hit[i]) low_idx = 2'(i);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg    <= 4'hF;
      sync2_reg    <= 4'hF;
      tick_cnt_reg <= 25'd1;
    end else begin
      sync1_reg    <= cols_in;
      sync2_reg    <= sync1_reg;
      tick_cnt_reg <= tick ? 25'd1 : tick_cnt_reg + 25'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= SCAN;
      rows_out    <= 4'b1110;
      row_idx_reg <= 2'd0;
      col_idx_reg <= 2'd0;
      deb_cnt_reg <= 4'd0;
      rel_cnt_reg <= 4'd0;
      keypad      <= 4'd0;
      key_strobe  <= 1'b0;
      key_held    <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_reg <= 16'd0;
`endif
    end else begin
      key_strobe <= 1'b0;
      if (tick) begin
        case (state_reg)
          SCAN: begin
            if (one_low) begin
              col_idx_reg <= low_idx;
              if (DEB_VAL == 4'd1) begin
                keypad      <= {row_idx_reg, low_idx};
                key_strobe  <= 1'b1;
                key_held    <= 1'b1;
                deb_cnt_reg <= 4'd0;
                rel_cnt_reg <= 4'd0;
                state_reg   <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt_reg <= 16'd0;
`endif
              end else begin
                deb_cnt_reg <= 4'd1;
                state_reg   <= DEBOUNCE;
              end
            end else begin
              rows_out    <= {rows_out[2:0], rows_out[3]};
              row_idx_reg <= row_idx_reg + 2'd1;
            end
          end

          DEBOUNCE: begin
            if (same_col) begin
              if (deb_cnt_reg + 4'd1 == DEB_VAL) begin
                keypad      <= {row_idx_reg, col_idx_reg};
                key_strobe  <= 1'b1;
                key_held    <= 1'b1;
                deb_cnt_reg <= 4'd0;
                rel_cnt_reg <= 4'd0;
                state_reg   <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_cnt_reg <= 16'd0;
`endif
              end else begin
                deb_cnt_reg <= deb_cnt_reg + 4'd1;
              end
            end else begin
              deb_cnt_reg <= 4'd0;
              state_reg   <= SCAN;
              rows_out    <= {rows_out[2:0], rows_out[3]};
              row_idx_reg <= row_idx_reg + 2'd1;
            end
          end

          PRESSED: begin
            // Release needs every column high; a second key only restarts the release count
            if (all_high) begin
              if (rel_cnt_reg + 4'd1 == DEB_VAL) begin
                key_held    <= 1'b0;
                rel_cnt_reg <= 4'd0;
                state_reg   <= SCAN;
                rows_out    <= {rows_out[2:0], rows_out[3]};
                row_idx_reg <= row_idx_reg + 2'd1;
              end else begin
                rel_cnt_reg <= rel_cnt_reg + 4'd1;
              end
            end else begin
              rel_cnt_reg <= 4'd0;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (same_col) begin
              if (rep_cnt_reg + 16'd1 == REP_VAL) begin
                key_strobe  <= 1'b1;
                rep_cnt_reg <= 16'd0;
              end else begin
                rep_cnt_reg <= rep_cnt_reg + 16'd1;
              end
            end else begin
              rep_cnt_reg <= 16'd0;
            end
`endif
          end

          default: state_reg <= SCAN;
        endcase
      end
    end
  end

endmodule
